// File: rtl/mem_init_pkg.sv
// Shared types and constants for the memory-initialisation sequencer.
package mem_init_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_CONST = 1'b0;
  localparam logic MODE_INC   = 1'b1;

endpackage

// File: rtl/mem_init_ctrl_if.sv
// Valid/ready write port driven by the initialisation sequencer.
interface mem_init_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/mem_init_sync.sv
// Control-input conditioning for mem_init_ctrl: optional per-bit
// synchronisers on init_en/init_abort plus start-edge detection.
// Build macro: MEMINIT_SYNC_EN (defined = SYNC_STAGES-flop synchronisers,
// undefined = inputs already synchronous to clk and used directly).
module mem_init_sync #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic abort_i,
  output logic en_s_o,
  output logic abort_s_o,
  output logic rise_o
);

  logic en_d_q;

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("mem_init_sync: SYNC_STAGES must be at least 2");
  end

`ifdef MEMINIT_SYNC_EN
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic [SYNC_STAGES-1:0] abort_sync_q;

  // Shift each control bit through its own flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync_q    <= '0;
      abort_sync_q <= '0;
    end else begin
      en_sync_q    <= {en_sync_q[SYNC_STAGES-2:0], en_i};
      abort_sync_q <= {abort_sync_q[SYNC_STAGES-2:0], abort_i};
    end
  end

  assign en_s_o    = en_sync_q[SYNC_STAGES-1];
  assign abort_s_o = abort_sync_q[SYNC_STAGES-1];
`else
  assign en_s_o    = en_i;
  assign abort_s_o = abort_i;
`endif

  // One-cycle-delayed copy of the conditioned enable for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d_q <= 1'b0;
    end else begin
      en_d_q <= en_s_o;
    end
  end

  assign rise_o = en_s_o & ~en_d_q;

endmodule

// File: rtl/mem_init_ctrl.sv
// Memory-initialisation sequencer: on a rising init_en, writes DEPTH words
// from BASE_ADDR over a valid/ready port with constant or incrementing data.
// Build macro: MEMINIT_SYNC_EN selects synchronised control inputs.
module mem_init_ctrl
  import mem_init_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       SYNC_STAGES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_en,
  input  logic                       init_abort,
  input  logic                       init_mode,
  input  logic [DATA_W-1:0]          fill_data,
  mem_init_ctrl_if.master            wr,
  output logic                       init_busy,
  output logic                       init_done,
  output logic                       init_done_pulse,
  output logic                       init_aborted,
  output logic [$clog2(DEPTH+1)-1:0] init_count
);

  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("mem_init_ctrl: DEPTH must be at least 1");
  end

  logic en_s;
  logic abort_s;
  logic rise;

  state_e            state_q,      state_d;
  logic [CNT_W-1:0]  count_q,      count_d;
  logic              mode_q,       mode_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] data_q,       data_d;
  logic              done_pulse_q, done_pulse_d;
  logic              aborted_q,    aborted_d;

  mem_init_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (init_en),
    .abort_i  (init_abort),
    .en_s_o   (en_s),
    .abort_s_o(abort_s),
    .rise_o   (rise)
  );

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      mode_q       <= MODE_CONST;
      addr_q       <= '0;
      data_q       <= '0;
      done_pulse_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      done_pulse_q <= done_pulse_d;
      aborted_q    <= aborted_d;
    end
  end

  // Next-state logic. The beat index always equals the accepted-beat count,
  // so one counter serves both; address and data are kept as running
  // registers (BASE+index and seed+index) instead of being re-added.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    data_d       = data_q;
    done_pulse_d = 1'b0;
    aborted_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          mode_d  = init_mode;
          count_d = '0;
          addr_d  = BASE_ADDR;
          data_d  = fill_data;
          state_d = RUN;
        end
      end

      RUN: begin
        if (wr.wr_ready) begin
          count_d = count_q + CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          if (mode_q == MODE_INC) begin
            data_d = data_q + DATA_W'(1);
          end
        end
        // Abort outranks completion, but a beat accepted alongside it counts.
        if (abort_s) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
          addr_d    = '0;
          data_d    = '0;
        end else if (wr.wr_ready && (count_q == LAST)) begin
          done_pulse_d = 1'b1;
          state_d      = DONE;
          addr_d       = '0;
          data_d       = '0;
        end
      end

      DONE: begin
        if (!en_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr.wr_valid     = (state_q == RUN);
  assign wr.wr_addr      = addr_q;
  assign wr.wr_data      = data_q;
  assign init_busy       = (state_q == RUN);
  assign init_done       = (state_q == DONE);
  assign init_done_pulse = done_pulse_q;
  assign init_aborted    = aborted_q;
  assign init_count      = count_q;

endmodule

// File: tb/tb_mem_init_ctrl.sv
// Directed self-checking bench for mem_init_ctrl; four instances cover the
// nominal sweep, stalled incrementing sweep, address wrap and DEPTH=1.
module tb_mem_init_ctrl;
  import mem_init_pkg::*;

  localparam int unsigned SYNC = 3;
`ifdef MEMINIT_SYNC_EN
  localparam int unsigned LAT = SYNC + 1;
  localparam int unsigned DLY = SYNC;
`else
  localparam int unsigned LAT = 1;
  localparam int unsigned DLY = 0;
`endif

  localparam int unsigned DEPTHS [4] = '{32, 8, 4, 1};
  localparam logic [31:0] BASES  [4] = '{32'h0, 32'h100, 32'hFFFF_FFFE, 32'h40};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en    [4];
  logic        abort [4];
  logic        mode  [4];
  logic        ready [4];
  logic [31:0] fill  [4];

  logic        vld    [4];
  logic        busy   [4];
  logic        done   [4];
  logic        dpulse [4];
  logic        abrt   [4];
  logic [31:0] addr   [4];
  logic [31:0] data   [4];
  logic [5:0]  cnt    [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned D = DEPTHS[g];
    logic [$clog2(D+1)-1:0] c;

    mem_init_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_init_ctrl #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .DEPTH      (D),
      .BASE_ADDR  (BASES[g]),
      .SYNC_STAGES(SYNC)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .init_en        (en[g]),
      .init_abort     (abort[g]),
      .init_mode      (mode[g]),
      .fill_data      (fill[g]),
      .wr             (bus),
      .init_busy      (busy[g]),
      .init_done      (done[g]),
      .init_done_pulse(dpulse[g]),
      .init_aborted   (abrt[g]),
      .init_count     (c)
    );

    assign bus.wr_ready = ready[g];
    assign vld[g]       = bus.wr_valid;
    assign addr[g]      = bus.wr_addr;
    assign data[g]      = bus.wr_data;
    assign cnt[g]       = 6'(c);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise init_en and check wr_valid appears exactly LAT edges later.
  task automatic start(input int i, input logic m, input logic [31:0] f);
    mode[i] = m;
    fill[i] = f;
    en[i]   = 1'b1;
    repeat (LAT - 1) step();
    chk("start_idle", 32'(vld[i]), 32'd0);
    step();
    chk("start_valid", 32'(vld[i]), 32'd1);
  endtask

  // Drop init_en, wait (bounded) for DONE to clear, then let the inputs settle.
  task automatic release_en(input int i, input logic [31:0] exp_cnt);
    int n = 0;
    en[i] = 1'b0;
    while (done[i] !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("release_done", 32'(done[i]), 32'd0);
    chk("release_cnt", 32'(cnt[i]), exp_cnt);
    repeat (SYNC + 2) step();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; abort[i] = 1'b0; mode[i] = 1'b0; ready[i] = 1'b0; fill[i] = '0;
    end
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", 32'(vld[i]), 32'd0);
      chk("rst_addr", addr[i], 32'd0);
      chk("rst_data", data[i], 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_done", 32'(done[i]), 32'd0);
      chk("rst_dpulse", 32'(dpulse[i]), 32'd0);
      chk("rst_aborted", 32'(abrt[i]), 32'd0);
      chk("rst_cnt", 32'(cnt[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (SYNC + 2) step();

    // Constant fill, ready always high, DEPTH=32.
    ready[0] = 1'b1;
    start(0, MODE_CONST, 32'hA5A5_A5A5);
    fill[0] = 32'h0;
    mode[0] = MODE_INC;
    for (int b = 0; b < 32; b++) begin
      chk("t1_valid", 32'(vld[0]), 32'd1);
      chk("t1_busy", 32'(busy[0]), 32'd1);
      chk("t1_addr", addr[0], 32'(b));
      chk("t1_data", data[0], 32'hA5A5_A5A5);
      chk("t1_cnt", 32'(cnt[0]), 32'(b));
      chk("t1_no_pulse", 32'(dpulse[0]), 32'd0);
      step();
    end
    chk("t1_pulse", 32'(dpulse[0]), 32'd1);
    chk("t1_done", 32'(done[0]), 32'd1);
    chk("t1_valid_off", 32'(vld[0]), 32'd0);
    chk("t1_busy_off", 32'(busy[0]), 32'd0);
    chk("t1_cnt32", 32'(cnt[0]), 32'd32);
    step();
    chk("t1_pulse_1cyc", 32'(dpulse[0]), 32'd0);
    chk("t1_done_held", 32'(done[0]), 32'd1);
    repeat (4) step();
    chk("t1_done_hold4", 32'(done[0]), 32'd1);
    chk("t1_valid_hold4", 32'(vld[0]), 32'd0);
    release_en(0, 32'd32);

    // Abort after five accepted beats, then restart from index 0.
    start(0, MODE_INC, 32'h1000);
    for (int b = 0; b < 5; b++) begin
      chk("t3_data", data[0], 32'h1000 + 32'(b));
      step();
    end
    chk("t3_cnt5", 32'(cnt[0]), 32'd5);
    chk("t3_addr5", addr[0], 32'd5);
    ready[0] = 1'b0;
    abort[0] = 1'b1;
    n = 0;
    while (abrt[0] !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("t3_aborted", 32'(abrt[0]), 32'd1);
    chk("t3_valid_off", 32'(vld[0]), 32'd0);
    chk("t3_busy_off", 32'(busy[0]), 32'd0);
    chk("t3_no_done", 32'(done[0]), 32'd0);
    chk("t3_no_pulse", 32'(dpulse[0]), 32'd0);
    chk("t3_cnt_kept", 32'(cnt[0]), 32'd5);
    abort[0] = 1'b0;
    step();
    chk("t3_aborted_1cyc", 32'(abrt[0]), 32'd0);
    chk("t3_idle_valid", 32'(vld[0]), 32'd0);
    release_en(0, 32'd5);
    start(0, MODE_CONST, 32'h77);
    chk("t3_restart_addr", addr[0], 32'd0);
    chk("t3_restart_cnt", 32'(cnt[0]), 32'd0);
    chk("t3_restart_data", data[0], 32'h77);

    // Incrementing fill with a stall before every beat, DEPTH=8 at 0x100.
    // A one-cycle drop of init_en mid-sweep must not disturb the sweep.
    ready[1] = 1'b0;
    start(1, MODE_INC, 32'h10);
    mode[1] = MODE_CONST;
    fill[1] = 32'hDEAD;
    for (int b = 0; b < 8; b++) begin
      chk("t2_valid", 32'(vld[1]), 32'd1);
      chk("t2_addr", addr[1], 32'h100 + 32'(b));
      chk("t2_data", data[1], 32'h10 + 32'(b));
      chk("t2_cnt", 32'(cnt[1]), 32'(b));
      if (b == 3) en[1] = 1'b0;
      step();
      chk("t2_stall_valid", 32'(vld[1]), 32'd1);
      chk("t2_stall_addr", addr[1], 32'h100 + 32'(b));
      chk("t2_stall_data", data[1], 32'h10 + 32'(b));
      chk("t2_stall_cnt", 32'(cnt[1]), 32'(b));
      en[1]    = 1'b1;
      ready[1] = 1'b1;
      step();
      ready[1] = 1'b0;
    end
    chk("t2_pulse", 32'(dpulse[1]), 32'd1);
    chk("t2_done", 32'(done[1]), 32'd1);
    chk("t2_cnt8", 32'(cnt[1]), 32'd8);

    // init_en held high in DONE: no restart, no further beats.
    ready[1] = 1'b1;
    repeat (4) step();
    chk("t4_done_held", 32'(done[1]), 32'd1);
    chk("t4_no_valid", 32'(vld[1]), 32'd0);
    chk("t4_no_pulse", 32'(dpulse[1]), 32'd0);
    chk("t4_cnt_held", 32'(cnt[1]), 32'd8);
    release_en(1, 32'd8);
    start(1, MODE_CONST, 32'h55);
    chk("t4_new_addr", addr[1], 32'h100);
    chk("t4_new_data", data[1], 32'h55);
    chk("t4_new_cnt", 32'(cnt[1]), 32'd0);
    repeat (7) step();
    chk("t4_last_addr", addr[1], 32'h107);
    chk("t4_last_data", data[1], 32'h55);
    step();
    chk("t4_new_done", 32'(done[1]), 32'd1);
    release_en(1, 32'd8);

    // DEPTH=1: abort coinciding with the only (last) beat, then a clean sweep.
    ready[3] = 1'b0;
    start(3, MODE_CONST, 32'hC3);
    chk("d1_addr", addr[3], 32'h40);
    chk("d1_data", data[3], 32'hC3);
    abort[3] = 1'b1;
    repeat (DLY) step();
    chk("d1_stalled", 32'(vld[3]), 32'd1);
    ready[3] = 1'b1;
    step();
    chk("d1_abort_wins", 32'(abrt[3]), 32'd1);
    chk("d1_abort_no_pulse", 32'(dpulse[3]), 32'd0);
    chk("d1_abort_no_done", 32'(done[3]), 32'd0);
    chk("d1_abort_cnt", 32'(cnt[3]), 32'd1);
    chk("d1_abort_valid", 32'(vld[3]), 32'd0);
    abort[3] = 1'b0;
    ready[3] = 1'b0;
    release_en(3, 32'd1);
    ready[3] = 1'b1;
    start(3, MODE_INC, 32'h9);
    chk("d1_run_addr", addr[3], 32'h40);
    chk("d1_run_data", data[3], 32'h9);
    step();
    chk("d1_pulse", 32'(dpulse[3]), 32'd1);
    chk("d1_done", 32'(done[3]), 32'd1);
    chk("d1_cnt", 32'(cnt[3]), 32'd1);
    chk("d1_valid_off", 32'(vld[3]), 32'd0);
    release_en(3, 32'd1);

    // Address and data wrap: BASE=0xFFFFFFFE, DEPTH=4, seed 0xFFFFFFFF.
    ready[2] = 1'b1;
    start(2, MODE_INC, 32'hFFFF_FFFF);
    chk("t5_addr0", addr[2], 32'hFFFF_FFFE);
    chk("t5_data0", data[2], 32'hFFFF_FFFF);
    step();
    chk("t5_addr1", addr[2], 32'hFFFF_FFFF);
    chk("t5_data1", data[2], 32'h0);
    step();
    chk("t5_addr2", addr[2], 32'h0);
    chk("t5_data2", data[2], 32'h1);
    step();
    chk("t5_addr3", addr[2], 32'h1);
    chk("t5_data3", data[2], 32'h2);
    step();
    chk("t5_done", 32'(done[2]), 32'd1);
    chk("t5_cnt", 32'(cnt[2]), 32'd4);
    release_en(2, 32'd4);

    // Reset asserted mid-sweep clears outputs without waiting for a clock.
    start(2, MODE_INC, 32'h5);
    step();
    step();
    chk("t5_mid_cnt", 32'(cnt[2]), 32'd2);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_valid", 32'(vld[2]), 32'd0);
    chk("rst_mid_addr", addr[2], 32'd0);
    chk("rst_mid_data", data[2], 32'd0);
    chk("rst_mid_busy", 32'(busy[2]), 32'd0);
    chk("rst_mid_cnt", 32'(cnt[2]), 32'd0);
    chk("rst_mid_done", 32'(done[2]), 32'd0);
    chk("rst_mid_pulse", 32'(dpulse[2]), 32'd0);
    chk("rst_mid_busy0", 32'(busy[0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
